pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Drives the 16-bit program counter and generates the 2-bit select for the PC source mux (inc / branch / jump / return). It contains a small return-address stack (RAS) for call/return. It sits between instruction decode, which supplies op/cond/offset/target, and the fetch address port. The PC mux consumes a select; this block is the end that produces the select and owns the registered PC.

Parameters:
PC_WIDTH, 16, PC and target width
OFF_WIDTH, 11, signed branch-offset width, two's complement
RAS_DEPTH, 4, return-stack entries; must be a power of 2, at least 2
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
stall  in  1  1 = hold all state this cycle
op  in  2  00 SEQ, 01 BRANCH, 10 JUMP, 11 RETURN
cond  in  1  branch-taken flag; used only for op=01
call  in  1  with op=10, push return address (pc+1)
offset  in  OFF_WIDTH  signed branch offset, relative to pc+1
target  in  PC_WIDTH  absolute jump target
pc  out  PC_WIDTH  current PC, registered
pc_sel  out  2  source chosen this cycle, combinational: 0 inc, 1 branch, 2 target, 3 stack
ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries, registered
ras_overflow  out  1  sticky: a push occurred while the stack was full
ras_underflow  out  1  sticky: a return occurred while the stack was empty

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, ras_count=0, both sticky flags=0, RAS contents don't-care. Deassertion is synchronised by the system; no extra requirement here.
- stall=1: pc, RAS, ras_count and flags hold. op, call and cond are ignored. pc_sel still reflects the decode of the current inputs; it is informational only.
- stall=0: pc updates on every rising edge. Latency is one cycle from inputs to the new pc.
- Next-PC rules, all arithmetic mod 2^PC_WIDTH (wrap, no saturation):
  - SEQ: pc+1. pc_sel=0.
  - BRANCH, cond=1: pc+1+sext(offset). pc_sel=1.
  - BRANCH, cond=0: pc+1. pc_sel=0.
  - JUMP: target. pc_sel=2. If call=1, push pc+1.
  - RETURN, ras_count>0: pop and load the top entry. pc_sel=3.
  - RETURN, ras_count=0: pc+1, set ras_underflow, ras_count stays 0. pc_sel=0.
- call is ignored for any op other than JUMP.
- Push when full (ras_count=RAS_DEPTH):
  - The oldest entry is overwritten; the stack is circular with its write pointer wrapping.
  - ras_count stays RAS_DEPTH.
  - ras_overflow is set.
- Sticky flags clear only on reset.
- At most one push or one pop per cycle. Push and pop in the same cycle cannot occur because op is exclusive.
- sext: bit OFF_WIDTH-1 is replicated up to PC_WIDTH.

Decomposition:
- Shared package (isa_pkg): op encodings (OP_SEQ, OP_BRANCH, OP_JUMP, OP_RETURN) and pc_sel encodings (SEL_INC, SEL_BR, SEL_TGT, SEL_RAS), so that decode, this block and the PC mux share the same codes.
- One sub-module, pc_ras:
  - Circular stack with push/pop/data_in/top/count/full/empty.
  - Async active-low reset clears count and pointers.
  - The top-level keeps the next-PC mux logic, the PC register and the sticky flags.

Test Plan:
- Reset then SEQ x3: after rst_n rises, pc steps 0000 → 0001 → 0002 → 0003. pc_sel=0 throughout. Asserting rst_n=0 mid-run forces pc=0000 immediately, without waiting for a clock edge.
- Branch: pc=0010.
  - offset=11'h7FE (−2), cond=1 → pc=000F, pc_sel=1.
  - offset=11'h3FF, cond=1 → pc=040F.
  - cond=0 → pc=0011.
  - Wrap case: pc=FFFF, SEQ → 0000.
- Call/return: pc=0100, JUMP target=0200 call=1 → pc=0200, ras_count=1. Then RETURN → pc=0101, ras_count=0, pc_sel=3.
- Overflow (RAS_DEPTH=4): 5 nested calls issued from pc=0010, 0020, 0030, 0040, 0050.
  - Required: ras_overflow=1, ras_count=4.
  - Then 4 returns yield 0051, 0041, 0031, 0021.
  - A 5th return gives underflow=1, with pc = previous+1.
- Stall: stall=1 with op=JUMP call=1 target=ABCD for 3 cycles → pc, ras_count and flags unchanged. Releasing stall with the same inputs → pc=ABCD, ras_count +1.
- JUMP call=0 and BRANCH call=1: RAS untouched, ras_count constant.

Source files
------------

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - op and pc_sel encodings shared by decode, the sequencer and the PC mux
package isa_pkg;

    typedef enum logic [1:0] {
        OP_SEQ    = 2'b00,
        OP_BRANCH = 2'b01,
        OP_JUMP   = 2'b10,
        OP_RETURN = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SEL_INC = 2'd0,
        SEL_BR  = 2'd1,
        SEL_TGT = 2'd2,
        SEL_RAS = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;
    // wr_ptr points at the next free slot, so the top sits one below it
    assign top   = mem_q[wr_ptr_q - PTR_ONE];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
            if (!full) count_d = count_q + CNT_ONE;
        end else if (pop && !empty) begin
            wr_ptr_d = wr_ptr_q - PTR_ONE;
            count_d  = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered program counter, next-PC source select and call/return stack
module pc_sequencer
    import isa_pkg::*;
#(
    parameter int                  PC_WIDTH  = 16,
    parameter int                  OFF_WIDTH = 11,
    parameter int                  RAS_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic [1:0]                 op,
    input  logic                       cond,
    input  logic                       call,
    input  logic [OFF_WIDTH-1:0]       offset,
    input  logic [PC_WIDTH-1:0]        target,
    output logic [PC_WIDTH-1:0]        pc,
    output logic [1:0]                 pc_sel,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [PC_WIDTH-1:0] pc_inc, off_sext, nxt_pc, ras_top;
    logic                push, pop, ras_full, ras_empty;
    pc_sel_e             sel;

    assign pc_inc   = pc_q + PC_WIDTH'(1);
    assign off_sext = {{(PC_WIDTH-OFF_WIDTH){offset[OFF_WIDTH-1]}}, offset};

    pc_ras #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .data_in (pc_inc),
        .top     (ras_top),
        .count   (ras_count),
        .full    (ras_full),
        .empty   (ras_empty)
    );

    // Decode runs even while stalled so pc_sel stays informative; only state updates are gated.
    always_comb begin
        sel    = SEL_INC;
        nxt_pc = pc_inc;
        push   = 1'b0;
        pop    = 1'b0;
        pc_d   = pc_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        case (op_e'(op))
            OP_BRANCH: if (cond) begin
                sel    = SEL_BR;
                nxt_pc = pc_inc + off_sext;
            end
            OP_JUMP: begin
                sel    = SEL_TGT;
                nxt_pc = target;
            end
            OP_RETURN: if (!ras_empty) begin
                sel    = SEL_RAS;
                nxt_pc = ras_top;
            end
            default: ;
        endcase
        if (!stall) begin
            pc_d = nxt_pc;
            if (op_e'(op) == OP_JUMP && call) begin
                push = 1'b1;
                if (ras_full) ovf_d = 1'b1;
            end
            if (op_e'(op) == OP_RETURN) begin
                if (ras_empty) unf_d = 1'b1;
                else           pop   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc            = pc_q;
    assign pc_sel        = sel;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed checks of pc_sequencer against hand-computed values
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  op;
    logic        cond;
    logic        call;
    logic [10:0] offset;
    logic [15:0] target;
    logic [15:0] pc;
    logic [1:0]  pc_sel;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .op            (op),
        .cond          (cond),
        .call          (call),
        .offset        (offset),
        .target        (target),
        .pc            (pc),
        .pc_sel        (pc_sel),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic c, input logic cl,
                         input logic [10:0] off, input logic [15:0] tgt);
        op = o; cond = c; call = cl; offset = off; target = tgt;
    endtask

    task automatic go_to(input logic [15:0] a);
        drive(2'b10, 1'b0, 1'b0, 11'h0, a);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 11'h0, 16'h0);
        repeat (2) step();
        check("rst_pc", pc, 16'h0000);
        check("rst_cnt", ras_count, 3'd0);
        check("rst_ovf", ras_overflow, 1'b0);
        check("rst_unf", ras_underflow, 1'b0);
        rst_n = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            check("seq_sel", pc_sel, 2'd0);
            step();
            check("seq_pc", pc, 16'(i));
        end

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 check("async_rst_pc", pc, 16'h0000);
        rst_n = 1'b1;
        step();

        go_to(16'h0010);
        check("jmp_nocall_cnt", ras_count, 3'd0);
        drive(2'b01, 1'b1, 1'b0, 11'h7FE, 16'h0);
        #1 check("br_sel", pc_sel, 2'd1);
        step();
        check("br_neg", pc, 16'h000F);
        drive(2'b01, 1'b1, 1'b0, 11'h3FF, 16'h0);
        step();
        check("br_pos", pc, 16'h040F);
        go_to(16'h0010);
        drive(2'b01, 1'b0, 1'b0, 11'h3FF, 16'h0);
        #1 check("br_nt_sel", pc_sel, 2'd0);
        step();
        check("br_nt", pc, 16'h0011);
        go_to(16'hFFFF);
        drive(2'b00, 1'b0, 1'b0, 11'h0, 16'h0);
        step();
        check("wrap", pc, 16'h0000);
        drive(2'b01, 1'b1, 1'b1, 11'h005, 16'h0);
        step();
        check("br_call_pc", pc, 16'h0006);
        check("br_call_cnt", ras_count, 3'd0);

        go_to(16'h0100);
        drive(2'b10, 1'b0, 1'b1, 11'h0, 16'h0200);
        step();
        check("call_pc", pc, 16'h0200);
        check("call_cnt", ras_count, 3'd1);
        drive(2'b11, 1'b0, 1'b0, 11'h0, 16'h0);
        #1 check("ret_sel", pc_sel, 2'd3);
        step();
        check("ret_pc", pc, 16'h0101);
        check("ret_cnt", ras_count, 3'd0);

        for (int i = 1; i <= 5; i++) begin
            go_to(16'(i * 16));
            drive(2'b10, 1'b0, 1'b1, 11'h0, 16'h1000);
            step();
            if (i == 4) check("ovf_before", ras_overflow, 1'b0);
        end
        check("ovf_flag", ras_overflow, 1'b1);
        check("ovf_cnt", ras_count, 3'd4);
        drive(2'b11, 1'b0, 1'b0, 11'h0, 16'h0);
        step(); check("ret1", pc, 16'h0051);
        step(); check("ret2", pc, 16'h0041);
        step(); check("ret3", pc, 16'h0031);
        step(); check("ret4", pc, 16'h0021);
        check("unf_before", ras_underflow, 1'b0);
        #1 check("unf_sel", pc_sel, 2'd0);
        step();
        check("unf_pc", pc, 16'h0022);
        check("unf_flag", ras_underflow, 1'b1);
        check("unf_cnt", ras_count, 3'd0);

        stall = 1'b1;
        drive(2'b10, 1'b0, 1'b1, 11'h0, 16'hABCD);
        #1 check("stall_sel", pc_sel, 2'd2);
        repeat (3) step();
        check("stall_pc", pc, 16'h0022);
        check("stall_cnt", ras_count, 3'd0);
        check("stall_ovf", ras_overflow, 1'b1);
        check("stall_unf", ras_underflow, 1'b1);
        stall = 1'b0;
        step();
        check("unstall_pc", pc, 16'hABCD);
        check("unstall_cnt", ras_count, 3'd1);
        check("sticky_ovf", ras_overflow, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
